// File: rtl/tmds_channel_decoder.sv
// One TMDS receive lane: 10b symbol -> 8b data / 2b control / DE, with lock tracking and disparity checking.
// Optional saturating error counter enabled by defining TMDS_DEC_ERRCNT_EN.
module tmds_channel_decoder #(
    parameter int CTRL_RUN     = 8,
    parameter int MAX_DATA_RUN = 1024,
    parameter int DISP_LIMIT   = 16
) (
    input  logic        pix_clk,
    input  logic        rst,
    input  logic        sym_valid,
    input  logic [9:0]  sym,
    output logic [7:0]  data,
    output logic [1:0]  ctrl,
    output logic        de,
    output logic        out_valid,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_count
);

    localparam int CRW = $clog2(CTRL_RUN + 1);
    localparam int DRW = $clog2(MAX_DATA_RUN + 1);
    localparam logic signed [7:0] LIM = 8'(DISP_LIMIT);

    // state    | meaning
    // UNLOCKED | hunting for CTRL_RUN back-to-back control tokens; outputs gated
    // LOCKED   | framing trusted; data/ctrl/de/err passed through
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t state;

    logic [9:0] q;
    logic [7:0] dec;
    logic       tok;
    logic [1:0] tok_ctrl;
    logic [3:0] pop;

    logic       s1_valid;
    logic       s1_tok;
    logic [1:0] s1_ctrl;
    logic [7:0] s1_data;
    logic [3:0] s1_pop;

    logic [CRW-1:0]    ctrl_run;
    logic [DRW-1:0]    data_run;
    logic [1:0]        last_ctrl;
    logic signed [7:0] rd;
    logic signed [7:0] rd_sum;
    logic              disp_err;

    always_comb begin
        q = sym[9] ? {sym[9:8], ~sym[7:0]} : sym;
        dec    = '0;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        tok      = 1'b1;
        tok_ctrl = 2'b00;
        case (sym)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        tok      = 1'b0;
        endcase
        pop = '0;
        for (int i = 0; i < 10; i++) begin
            pop = pop + 4'(sym[i]);
        end
    end

    always_ff @(posedge pix_clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_tok   <= 1'b0;
            s1_ctrl  <= 2'b00;
            s1_data  <= 8'h00;
            s1_pop   <= 4'd0;
        end else begin
            s1_valid <= sym_valid;
            if (sym_valid) begin
                s1_tok  <= tok;
                s1_ctrl <= tok_ctrl;
                s1_data <= dec;
                s1_pop  <= pop;
            end
        end
    end

    // Each symbol moves disparity by 2*popcount - 10.
    always_comb begin
        rd_sum   = rd + $signed({3'b000, s1_pop, 1'b0}) - 8'sd10;
        disp_err = (rd_sum > LIM) || (rd_sum < -LIM);
    end

    always_ff @(posedge pix_clk or negedge rst) begin
        if (!rst) begin
            state     <= UNLOCKED;
            locked    <= 1'b0;
            ctrl_run  <= '0;
            data_run  <= '0;
            last_ctrl <= 2'b00;
            rd        <= 8'sd0;
            data      <= 8'h00;
            ctrl      <= 2'b00;
            de        <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            err       <= 1'b0;
            if (s1_valid) begin
                if (s1_tok) begin
                    last_ctrl <= s1_ctrl;
                    rd        <= 8'sd0;
                    data      <= 8'h00;
                    de        <= 1'b0;
                    case (state)
                        UNLOCKED: begin
                            if (ctrl_run == CRW'(CTRL_RUN - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                ctrl_run <= '0;
                                data_run <= '0;
                                ctrl     <= s1_ctrl;
                            end else begin
                                ctrl_run <= ctrl_run + 1'b1;
                                ctrl     <= 2'b00;
                            end
                        end
                        LOCKED: begin
                            data_run <= '0;
                            ctrl     <= s1_ctrl;
                        end
                    endcase
                end else begin
                    rd <= disp_err ? 8'sd0 : rd_sum;
                    case (state)
                        UNLOCKED: begin
                            ctrl_run <= '0;
                            data     <= 8'h00;
                            ctrl     <= 2'b00;
                            de       <= 1'b0;
                        end
                        LOCKED: begin
                            // Lock loss takes priority over a same-cycle disparity error.
                            if (data_run == DRW'(MAX_DATA_RUN - 1)) begin
                                state    <= UNLOCKED;
                                locked   <= 1'b0;
                                data_run <= '0;
                                ctrl_run <= '0;
                                data     <= 8'h00;
                                ctrl     <= 2'b00;
                                de       <= 1'b0;
                            end else begin
                                data_run <= data_run + 1'b1;
                                data     <= s1_data;
                                ctrl     <= last_ctrl;
                                de       <= 1'b1;
                                err      <= disp_err;
                            end
                        end
                    endcase
                end
            end
        end
    end

`ifdef TMDS_DEC_ERRCNT_EN
    always_ff @(posedge pix_clk or negedge rst) begin
        if (!rst) begin
            err_count <= 16'h0000;
        end else if (err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'h0001;
        end
    end
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock acquisition, control decode, data decode,
// lock loss on long data runs, disparity error pulse and asynchronous reset.
module tb_tmds_channel_decoder;

    logic        pix_clk;
    logic        rst;
    logic        sym_valid;
    logic [9:0]  sym;
    logic [7:0]  data;
    logic [1:0]  ctrl;
    logic        de;
    logic        out_valid;
    logic        locked;
    logic        err;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    localparam logic [9:0] T00  = 10'b1101010100;
    localparam logic [9:0] T01  = 10'b0010101011;
    localparam logic [9:0] T10  = 10'b0101010100;
    localparam logic [9:0] T11  = 10'b1010101011;
    localparam logic [9:0] BAL  = 10'b0000011111;  // popcount 5, decodes to 8'hDF
    localparam logic [9:0] HEAVY = 10'b1111110101; // popcount 8, decodes to 8'h1E

`ifdef TMDS_DEC_ERRCNT_EN
    localparam logic [15:0] EXP_CNT = 16'd1;
`else
    localparam logic [15:0] EXP_CNT = 16'd0;
`endif

    tmds_channel_decoder dut (
        .pix_clk   (pix_clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym       (sym),
        .data      (data),
        .ctrl      (ctrl),
        .de        (de),
        .out_valid (out_valid),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    initial pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One symbol surrounded by idle cycles; output must appear exactly two edges later.
    task automatic send_chk(input logic [9:0] s, input logic [7:0] ed, input logic [1:0] ec,
                            input logic ede, input logic el, input logic ee, input string tag);
        sym       = s;
        sym_valid = 1'b1;
        @(posedge pix_clk); #1;
        sym_valid = 1'b0;
        chk({tag, "_early"}, {15'd0, out_valid}, 16'd0);
        @(posedge pix_clk); #1;
        chk({tag, "_valid"},  {15'd0, out_valid}, 16'd1);
        chk({tag, "_data"},   {8'd0, data},       {8'd0, ed});
        chk({tag, "_ctrl"},   {14'd0, ctrl},      {14'd0, ec});
        chk({tag, "_de"},     {15'd0, de},        {15'd0, ede});
        chk({tag, "_locked"}, {15'd0, locked},    {15'd0, el});
        chk({tag, "_err"},    {15'd0, err},       {15'd0, ee});
    endtask

    task automatic stream(input logic [9:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            sym       = s;
            sym_valid = 1'b1;
            @(posedge pix_clk); #1;
        end
        sym_valid = 1'b0;
        repeat (2) @(posedge pix_clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        sym_valid = 1'b0;
        sym       = '0;
        repeat (2) @(posedge pix_clk);
        #1;
        chk("rst_outs", {data, ctrl, de, out_valid, locked, err, 2'b00}, 16'd0);
        chk("rst_cnt", err_count, 16'd0);
        rst = 1'b1;
        repeat (2) @(posedge pix_clk);
        #1;

        // Lock acquisition: seven tokens stay unlocked, the eighth locks.
        for (int i = 0; i < 7; i++) send_chk(T00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "acq");
        send_chk(T00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, "acq8");

        send_chk(T01, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0, "tok01");
        send_chk(T10, 8'h00, 2'b10, 1'b0, 1'b1, 1'b0, "tok10");
        send_chk(T11, 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, "tok11");

        // Data: ctrl holds last token value; rd goes -8 then -16 (not over limit).
        send_chk(10'b0100000000, 8'h00, 2'b11, 1'b1, 1'b1, 1'b0, "dat_xor");
        send_chk(10'b1000000000, 8'hFF, 2'b11, 1'b1, 1'b1, 1'b0, "dat_inv");

        // Long data run: 1023 symbols keep lock, the 1024th drops it.
        send_chk(T00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, "run_tok");
        stream(BAL, 1023);
        chk("run1023_locked", {15'd0, locked}, 16'd1);
        chk("run1023_data", {8'd0, data}, 16'h00DF);
        send_chk(BAL, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "run1024");

        // Relock, then a token right at the limit keeps lock.
        stream(T00, 8);
        chk("relock", {15'd0, locked}, 16'd1);
        stream(BAL, 1023);
        send_chk(T01, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0, "lim_tok");
        send_chk(BAL, 8'hDF, 2'b01, 1'b1, 1'b1, 1'b0, "lim_after");

        // Disparity: +6 per symbol from rd=0, third symbol reaches 18.
        send_chk(T00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, "disp_tok");
        send_chk(HEAVY, 8'h1E, 2'b00, 1'b1, 1'b1, 1'b0, "disp1");
        send_chk(HEAVY, 8'h1E, 2'b00, 1'b1, 1'b1, 1'b0, "disp2");
        send_chk(HEAVY, 8'h1E, 2'b00, 1'b1, 1'b1, 1'b1, "disp3");
        send_chk(HEAVY, 8'h1E, 2'b00, 1'b1, 1'b1, 1'b0, "disp4");
        chk("err_count", err_count, EXP_CNT);

        // Asynchronous reset in the middle of a data run.
        sym       = BAL;
        sym_valid = 1'b1;
        repeat (5) @(posedge pix_clk);
        #1;
        chk("pre_rst_de", {15'd0, de}, 16'd1);
        rst = 1'b0;
        #2;
        chk("async_rst_outs", {data, ctrl, de, out_valid, locked, err, 2'b00}, 16'd0);
        chk("async_rst_cnt", err_count, 16'd0);
        sym_valid = 1'b0;
        @(posedge pix_clk); #1;
        rst = 1'b1;
        @(posedge pix_clk); #1;
        stream(T00, 7);
        chk("post_rst_7tok", {15'd0, locked}, 16'd0);
        send_chk(T00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, "post_rst_8tok");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
